// File: rtl/dcache_if.sv
// Core-side and memory-side signals of the data cache controller.
interface dcache_if #(
   parameter int LINE_W = 256
);
   logic              core_req_i;
   logic              core_we_i;
   logic [31:0]       core_addr_i;
   logic [31:0]       core_wdata_i;
   logic [31:0]       core_rdata_o;
   logic              mem_stall_o;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [31:0]       mem_addr_o;
   logic [LINE_W-1:0] mem_wdata_o;
   logic [LINE_W-1:0] mem_rdata_i;
   logic              mem_ack_i;

   modport slave (
      input  core_req_i, core_we_i, core_addr_i, core_wdata_i,
      output core_rdata_o, mem_stall_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i, mem_ack_i
   );

   modport master (
      output core_req_i, core_we_i, core_addr_i, core_wdata_i,
      input  core_rdata_o, mem_stall_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i, mem_ack_i
   );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate data cache controller.
// Define DCACHE_STATS_EN to add hit_cnt_o/miss_cnt_o counters.
module dcache_ctrl #(
   parameter int NUM_LINES = 32,
   parameter int LINE_W    = 256
) (
   input  logic        clk_i,
   input  logic        rst_i,
`ifdef DCACHE_STATS_EN
   output logic [31:0] hit_cnt_o,
   output logic [31:0] miss_cnt_o,
`endif
   dcache_if.slave     bus
);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = 32 - 5 - IDX_W;

   typedef enum logic [1:0] {IDLE, WB, FILL} state_e;

   state_e state_q, state_d;

   logic [LINE_W-1:0] data_q [NUM_LINES];
   logic [TAG_W-1:0]  tag_q  [NUM_LINES];
   logic [NUM_LINES-1:0] valid_q, dirty_q;

   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [31:0]       miss_addr_q, miss_addr_d;

   logic [IDX_W-1:0]  req_idx, miss_idx;
   logic [TAG_W-1:0]  req_tag, miss_tag;
   logic [2:0]        req_word;
   logic [LINE_W-1:0] req_line;
   logic              hit, idle, st_hit, fill_done;
   logic              unused_addr;

   assign req_idx  = bus.core_addr_i[4+IDX_W:5];
   assign req_tag  = bus.core_addr_i[31:5+IDX_W];
   assign req_word = bus.core_addr_i[4:2];
   assign miss_idx = miss_addr_q[4+IDX_W:5];
   assign miss_tag = miss_addr_q[31:5+IDX_W];
   assign req_line = data_q[req_idx];
   assign unused_addr = ^bus.core_addr_i[1:0];

   assign hit = bus.core_req_i & valid_q[req_idx]
              & (tag_q[req_idx] == req_tag);
   assign idle      = (state_q == IDLE);
   assign st_hit    = hit & idle & bus.core_we_i;
   assign fill_done = (state_q == FILL) & bus.mem_ack_i;

   assign bus.mem_stall_o  = bus.core_req_i & (~hit | ~idle);
   assign bus.core_rdata_o = (hit & idle & ~bus.core_we_i)
                           ? req_line[{req_word, 5'b0} +: 32] : '0;

   assign bus.mem_req_o   = mem_req_q;
   assign bus.mem_we_o    = mem_we_q;
   assign bus.mem_addr_o  = mem_addr_q;
   assign bus.mem_wdata_o = mem_wdata_q;

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      miss_addr_d = miss_addr_q;
      unique case (state_q)
         IDLE: begin
            if (bus.core_req_i & ~hit) begin
               // Latch the miss address; the core may drop req mid-miss.
               miss_addr_d = bus.core_addr_i;
               mem_req_d   = 1'b1;
               if (valid_q[req_idx] & dirty_q[req_idx]) begin
                  state_d     = WB;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = {tag_q[req_idx], req_idx, 5'b0};
                  mem_wdata_d = data_q[req_idx];
               end else begin
                  state_d    = FILL;
                  mem_we_d   = 1'b0;
                  mem_addr_d = {req_tag, req_idx, 5'b0};
               end
            end
         end
         WB: begin
            if (bus.mem_ack_i) begin
               state_d    = FILL;
               mem_we_d   = 1'b0;
               mem_addr_d = {miss_addr_q[31:5], 5'b0};
            end
         end
         FILL: begin
            if (bus.mem_ack_i) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         dirty_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         miss_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         miss_addr_q <= miss_addr_d;
         if (fill_done) begin
            valid_q[miss_idx] <= 1'b1;
            dirty_q[miss_idx] <= 1'b0;
         end else if (st_hit) begin
            dirty_q[req_idx] <= 1'b1;
         end
      end
   end

   // Line storage is deliberately left uncleared by reset.
   always_ff @(posedge clk_i) begin
      if (fill_done) begin
         data_q[miss_idx] <= bus.mem_rdata_i;
         tag_q[miss_idx]  <= miss_tag;
      end else if (st_hit) begin
         data_q[req_idx][{req_word, 5'b0} +: 32] <= bus.core_wdata_i;
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (hit & idle & (hit_cnt_q != '1))
            hit_cnt_q <= hit_cnt_q + 32'd1;
         if (idle & bus.core_req_i & ~hit & (miss_cnt_q != '1))
            miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`endif
endmodule
